// File: rtl/pcileech_tlp_tx_arb.sv
// Two-source AXI-Stream TLP arbiter feeding the PCIe core TX port.
// Grants are packet-atomic: a source keeps the port until its tlast beat.
module pcileech_tlp_tx_arb #(
    parameter int PARAM_PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [63:0] s0_tdata,
    input  logic [7:0]  s0_tkeep,
    input  logic        s0_tlast,
    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic [63:0] s1_tdata,
    input  logic [7:0]  s1_tkeep,
    input  logic        s1_tlast,
    input  logic        s1_tvalid,
    output logic        s1_tready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic prio_s1 = (PARAM_PRIO_MODE == 1);

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   last_grant_nxt;
    logic   beat0;
    logic   beat1;

    // Valid/ready: a beat transfers on any rising edge where tvalid and tready
    // are both high; tvalid never depends on tready, tready may depend on tvalid.
    assign beat0 = (state == GNT0) && s0_tvalid && m_tready;
    assign beat1 = (state == GNT1) && s1_tvalid && m_tready;

    assign fsm_state = state;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (en) begin
                    if (s0_tvalid && s1_tvalid) begin
                        // Round-robin favours whichever source did not win last time.
                        if (prio_s1 || !last_grant) begin
                            state_nxt = GNT1;
                        end else begin
                            state_nxt = GNT0;
                        end
                    end else if (s0_tvalid) begin
                        state_nxt = GNT0;
                    end else if (s1_tvalid) begin
                        state_nxt = GNT1;
                    end
                end
            end
            GNT0: begin
                if (beat0 && s0_tlast) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (beat1 && s1_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state == IDLE && state_nxt == GNT0) begin
            last_grant_nxt = 1'b0;
        end else if (state == IDLE && state_nxt == GNT1) begin
            last_grant_nxt = 1'b1;
        end
    end

    always_comb begin
        m_tdata   = 64'd0;
        m_tkeep   = 8'd0;
        m_tlast   = 1'b0;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        busy      = 1'b0;
        case (state)
            GNT0: begin
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tlast   = s0_tlast;
                m_tvalid  = s0_tvalid;
                s0_tready = m_tready;
                busy      = 1'b1;
            end
            GNT1: begin
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tlast   = s1_tlast;
                m_tvalid  = s1_tvalid;
                s1_tready = m_tready;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Reset leaves last_grant pointing at source 1 so source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_cnt0   <= 16'd0;
            pkt_cnt1   <= 16'd0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            pkt_cnt0   <= pkt_cnt0 + {15'd0, beat0 && s0_tlast};
            pkt_cnt1   <= pkt_cnt1 + {15'd0, beat1 && s1_tlast};
        end
    end

endmodule

// File: tb/tb_pcileech_tlp_tx_arb.sv
// Bench for pcileech_tlp_tx_arb: a cycle table for round-robin contention plus
// directed multi-cycle sequences against a round-robin and a priority instance.
module tb_pcileech_tlp_tx_arb;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [63:0] DA = 64'hA000;
    localparam logic [63:0] DB = 64'hB000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [63:0] s0_tdata, s1_tdata;
    logic [7:0]  s0_tkeep, s1_tkeep;
    logic        s0_tlast, s0_tvalid, s1_tlast, s1_tvalid;
    logic        m_tready;
    logic        sel;

    logic [63:0] a_m_tdata, b_m_tdata;
    logic [7:0]  a_m_tkeep, b_m_tkeep;
    logic        a_m_tlast, b_m_tlast, a_m_tvalid, b_m_tvalid;
    logic        a_s0_tready, b_s0_tready, a_s1_tready, b_s1_tready;
    logic [15:0] a_cnt0, b_cnt0, a_cnt1, b_cnt1;
    logic        a_busy, b_busy;
    logic [1:0]  a_st, b_st;

    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast, m_tvalid, s0_tready, s1_tready, busy;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  st;

    pcileech_tlp_tx_arb #(.PARAM_PRIO_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(a_s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(a_s1_tready),
        .m_tdata(a_m_tdata), .m_tkeep(a_m_tkeep), .m_tlast(a_m_tlast),
        .m_tvalid(a_m_tvalid), .m_tready(m_tready),
        .pkt_cnt0(a_cnt0), .pkt_cnt1(a_cnt1), .busy(a_busy), .fsm_state(a_st)
    );

    pcileech_tlp_tx_arb #(.PARAM_PRIO_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(b_s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(b_s1_tready),
        .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tlast(b_m_tlast),
        .m_tvalid(b_m_tvalid), .m_tready(m_tready),
        .pkt_cnt0(b_cnt0), .pkt_cnt1(b_cnt1), .busy(b_busy), .fsm_state(b_st)
    );

    // The instance under test is chosen by sel; the other sees the same inputs.
    assign m_tdata   = sel ? b_m_tdata   : a_m_tdata;
    assign m_tkeep   = sel ? b_m_tkeep   : a_m_tkeep;
    assign m_tlast   = sel ? b_m_tlast   : a_m_tlast;
    assign m_tvalid  = sel ? b_m_tvalid  : a_m_tvalid;
    assign s0_tready = sel ? b_s0_tready : a_s0_tready;
    assign s1_tready = sel ? b_s1_tready : a_s1_tready;
    assign busy      = sel ? b_busy      : a_busy;
    assign cnt0      = sel ? b_cnt0      : a_cnt0;
    assign cnt1      = sel ? b_cnt1      : a_cnt1;
    assign st        = sel ? b_st        : a_st;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic [63:0] exp_q[$];
    logic gate0, gate1;

    typedef struct {
        logic        en;
        logic        v0;
        logic        l0;
        logic [63:0] d0;
        logic        v1;
        logic        l1;
        logic [63:0] d1;
        logic [1:0]  e_state;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_last;
        logic [15:0] e_c0;
        logic [15:0] e_c1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en_i, input logic v0, input logic l0,
                                input logic [63:0] d0, input logic v1, input logic l1,
                                input logic [63:0] d1, input logic [1:0] es, input logic ev,
                                input logic [63:0] ed, input logic el,
                                input logic [15:0] c0, input logic [15:0] c1);
        vec_t v;
        v.en = en_i; v.v0 = v0; v.l0 = l0; v.d0 = d0;
        v.v1 = v1; v.l1 = l1; v.d1 = d1;
        v.e_state = es; v.e_valid = ev; v.e_data = ed; v.e_last = el;
        v.e_c0 = c0; v.e_c1 = c1;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        s0_tvalid = gate0 && (q0.size() > 0);
        s0_tdata  = (q0.size() > 0) ? q0[0][63:0] : 64'd0;
        s0_tlast  = (q0.size() > 0) ? q0[0][64] : 1'b0;
        s1_tvalid = gate1 && (q1.size() > 0);
        s1_tdata  = (q1.size() > 0) ? q1[0][63:0] : 64'd0;
        s1_tlast  = (q1.size() > 0) ? q1[0][64] : 1'b0;
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic push_pkt(input int src, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (src == 0) q0.push_back({(i == n - 1), base + 64'(i)});
            else          q1.push_back({(i == n - 1), base + 64'(i)});
        end
    endtask

    task automatic expect_pkt(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(i));
    endtask

    // One clock: sample handshakes away from the edge, then advance sources.
    task automatic cyc();
        logic hs0, hs1, mb;
        hs0 = s0_tvalid && s0_tready;
        hs1 = s1_tvalid && s1_tready;
        mb  = m_tvalid && m_tready;
        if (mb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h, expected no beat", m_tdata);
            end else begin
                check("beat_data", m_tdata, exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        @(negedge clk);
        settle();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || st != ST_IDLE) && n < budget) begin
            cyc();
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        gate0 = 1'b0;
        gate1 = 1'b0;
        en = 1'b0;
        m_tready = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] a, b;
        logic more;
        logic [1:0]  wrap_st[7];
        logic [15:0] wrap_cnt[7];
        sel = 1'b0;
        s0_tkeep = 8'hFF;
        s1_tkeep = 8'h0F;
        reset_dut();

        check("rst_a", {a_st, a_m_tvalid, a_s0_tready, a_s1_tready, a_busy, a_cnt0, a_cnt1}, 0);
        check("rst_b", {b_st, b_m_tvalid, b_s0_tready, b_s1_tready, b_busy, b_cnt0, b_cnt1}, 0);

        // Round-robin contention: en low holds IDLE, then s0,s1,s0,s1,s0,s1.
        tbl.push_back(mk(0, 1, 0, DA, 1, 0, DB, ST_IDLE, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, DA, 1, 0, DB, ST_IDLE, 0, 0, 0, 0, 0));
        for (int r = 0; r < 3; r++) begin
            a = DA + 64'(2 * r);
            b = DB + 64'(2 * r);
            more = (r < 2);
            tbl.push_back(mk(1, 1, 0, a, 1, 0, b, ST_IDLE, 0, 0, 0, 16'(r), 16'(r)));
            tbl.push_back(mk(1, 1, 0, a, 1, 0, b, ST_GNT0, 1, a, 0, 16'(r), 16'(r)));
            tbl.push_back(mk(1, 1, 1, a + 1, 1, 0, b, ST_GNT0, 1, a + 1, 1, 16'(r), 16'(r)));
            tbl.push_back(mk(1, more, 0, a + 2, 1, 0, b, ST_IDLE, 0, 0, 0, 16'(r + 1), 16'(r)));
            tbl.push_back(mk(1, more, 0, a + 2, 1, 0, b, ST_GNT1, 1, b, 0, 16'(r + 1), 16'(r)));
            tbl.push_back(mk(1, more, 0, a + 2, 1, 1, b + 1, ST_GNT1, 1, b + 1, 1, 16'(r + 1), 16'(r)));
        end
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0, 3, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            logic [7:0] ek;
            en = tbl[i].en;
            s0_tvalid = tbl[i].v0; s0_tlast = tbl[i].l0; s0_tdata = tbl[i].d0;
            s1_tvalid = tbl[i].v1; s1_tlast = tbl[i].l1; s1_tdata = tbl[i].d1;
            m_tready = 1'b1;
            #1;
            ek = (tbl[i].e_state == ST_GNT0) ? 8'hFF : (tbl[i].e_state == ST_GNT1) ? 8'h0F : 8'h00;
            check($sformatf("vec%0d", i),
                  {st, m_tvalid, m_tdata, m_tlast, m_tkeep, s0_tready, s1_tready, busy, cnt0, cnt1},
                  {tbl[i].e_state, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_last, ek,
                   tbl[i].e_state == ST_GNT0, tbl[i].e_state == ST_GNT1,
                   tbl[i].e_state != ST_IDLE, tbl[i].e_c0, tbl[i].e_c1});
            @(posedge clk);
            @(negedge clk);
        end

        // Strict priority: s1 wins every IDLE, but never preempts a granted s0 packet.
        sel = 1'b1;
        reset_dut();
        push_pkt(0, 64'h100, 4); push_pkt(0, 64'h104, 4);
        push_pkt(1, 64'h200, 4); push_pkt(1, 64'h204, 4);
        expect_pkt(64'h100, 4); expect_pkt(64'h200, 4);
        expect_pkt(64'h204, 4); expect_pkt(64'h104, 4);
        gate0 = 1'b1; en = 1'b1;
        settle();
        cyc();
        check("prio_first_gnt0", st, ST_GNT0);
        gate1 = 1'b1;
        settle();
        for (int n = 0; n < 40 && (q0.size() > 0 || q1.size() > 0 || st != ST_IDLE); n++) begin
            logic pend;
            pend = (st == ST_IDLE) && s1_tvalid;
            cyc();
            if (pend) check("prio_s1_grant", st, ST_GNT1);
        end
        check("prio_all_beats", exp_q.size(), 0);
        check("prio_cnts", {cnt0, cnt1}, {16'd2, 16'd2});

        // en dropped mid-packet: packet finishes, then IDLE holds until en returns.
        sel = 1'b0;
        reset_dut();
        push_pkt(0, 64'h300, 5); push_pkt(1, 64'h400, 2);
        expect_pkt(64'h300, 5); expect_pkt(64'h400, 2);
        gate0 = 1'b1; en = 1'b1;
        settle();
        cyc();
        check("en_gnt0", st, ST_GNT0);
        cyc();
        en = 1'b0; gate1 = 1'b1;
        settle();
        for (int n = 0; n < 10 && q0.size() > 0; n++) begin
            check("en_hold_gnt0", st, ST_GNT0);
            cyc();
        end
        check("en_s0_done", {q0.size() == 0, exp_q.size()}, {1'b1, 32'd2});
        for (int n = 0; n < 3; n++) begin
            check("en_idle_hold", {st, m_tvalid, busy, s1_tvalid}, {ST_IDLE, 1'b0, 1'b0, 1'b1});
            cyc();
        end
        en = 1'b1;
        settle();
        check("en_req_cycle", st, ST_IDLE);
        cyc();
        check("en_gnt1_latency", st, ST_GNT1);
        drain("en_drain", 10);
        check("en_cnts", {cnt0, cnt1, exp_q.size()}, {16'd1, 16'd1, 32'd0});

        // Backpressure and source gaps mid-packet.
        reset_dut();
        push_pkt(0, 64'h500, 4);
        expect_pkt(64'h500, 4);
        gate0 = 1'b1; en = 1'b1;
        settle();
        cyc();
        cyc();
        m_tready = 1'b0;
        settle();
        for (int n = 0; n < 3; n++) begin
            check("bp_hold", {st, m_tvalid, m_tdata}, {ST_GNT0, 1'b1, 64'h501});
            cyc();
        end
        m_tready = 1'b1; gate0 = 1'b0;
        settle();
        for (int n = 0; n < 2; n++) begin
            check("gap_hold", {st, m_tvalid, s0_tready}, {ST_GNT0, 1'b0, 1'b1});
            cyc();
        end
        gate0 = 1'b1;
        settle();
        drain("bp_drain", 10);
        check("bp_done", {cnt0, exp_q.size()}, {16'd1, 32'd0});

        // Counter wrap: preset pkt_cnt1 to 0xFFFE, then three single-beat packets.
        reset_dut();
        force dut_a.pkt_cnt1 = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut_a.pkt_cnt1;
        #1;
        check("wrap_preset", cnt1, 16'hFFFE);
        push_pkt(1, 64'h600, 1); push_pkt(1, 64'h601, 1); push_pkt(1, 64'h602, 1);
        expect_pkt(64'h600, 3);
        gate1 = 1'b1; en = 1'b1;
        settle();
        wrap_st  = '{ST_IDLE, ST_GNT1, ST_IDLE, ST_GNT1, ST_IDLE, ST_GNT1, ST_IDLE};
        wrap_cnt = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
        for (int i = 0; i < 7; i++) begin
            check($sformatf("wrap_c%0d", i), {st, cnt1}, {wrap_st[i], wrap_cnt[i]});
            cyc();
        end

        // Reset on beat 3 of a 6-beat s1 packet.
        reset_dut();
        push_pkt(1, 64'h6F0, 1); push_pkt(1, 64'h700, 6);
        expect_pkt(64'h6F0, 1); expect_pkt(64'h700, 6);
        gate1 = 1'b1; en = 1'b1;
        settle();
        cyc();
        cyc();
        check("rst_pre_cnt1", cnt1, 16'd1);
        cyc();
        cyc();
        cyc();
        check("rst_beat3", {m_tvalid, m_tdata}, {1'b1, 64'h702});
        rst_n = 1'b0;
        #1;
        check("rst_async", {st, m_tvalid, s0_tready, s1_tready, busy, cnt1},
              {ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        q0.delete(); q1.delete(); exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(0, 64'h800, 1); push_pkt(1, 64'h900, 1);
        expect_pkt(64'h800, 1); expect_pkt(64'h900, 1);
        gate0 = 1'b1; gate1 = 1'b1;
        settle();
        check("rst_resume_idle", st, ST_IDLE);
        cyc();
        check("rst_first_gnt0", st, ST_GNT0);
        drain("rst_drain", 10);
        check("rst_final", {cnt0, cnt1, exp_q.size()}, {16'd1, 16'd1, 32'd0});

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
